switch_output_port: RTL and testbench
=====================================

// Module: switch_output_port
// PURPOSE
//  Output-port stage directly downstream of the 4-input fixed-priority arbiter.
//  Consumes the registered one-hot grant, locks to the winning input for a whole packet,
//  and forwards that input's flits through a one-entry registered output stage (valid/ready).
//  Releases the lock after the tail flit is accepted; a one-cycle pulse tells the arbiter
//  side that the port is free.
// PARAMETERS
//  N_PORTS        4   number of inputs; width of the grant vector
//  DATA_W         32  flit data width
//  MAX_PKT_FLITS  16  watchdog limit; packets longer than this are truncated
// PORTS
//  clk            in   1               clock, rising edge
//  reset_n        in   1               asynchronous reset, active low
//  i_gnt          in   N_PORTS         one-hot grant from arbiter (registered); 0 = none
//  i_valid        in   N_PORTS         per-input flit valid
//  i_data         in   N_PORTS*DATA_W  per-input flit data; input k = [k*DATA_W +: DATA_W]
//  i_last         in   N_PORTS         per-input tail-flit marker
//  o_ready        out  N_PORTS         per-input accept; only the owner bit can be 1
//  o_valid        out  1               output flit valid (registered)
//  o_data         out  DATA_W          output flit data (registered)
//  o_last         out  1               output tail marker (registered)
//  i_out_ready    in   1               downstream accept
//  o_busy         out  1               1 while the port is locked to an owner
//  o_owner        out  N_PORTS         one-hot current owner; 0 when idle
//  o_release      out  1               one-cycle pulse when the lock is released
//  o_pkt_cnt      out  16              packets delivered (tail accepted downstream); wraps
//  i_err_clr      in   1               clears the sticky error flags
//  o_err_multi    out  1               sticky: multi-hot grant seen in IDLE
//  o_err_len      out  1               sticky: watchdog truncated a packet
// BEHAVIOUR
//  Reset: all outputs are 0; state is IDLE; the output register is emptied.
//   Reset mid-packet drops the in-flight flit and the lock.
//  FSM IDLE:
//   - One-hot i_gnt: latch owner <= i_gnt, flit_cnt <= 0, go to XFER next cycle.
//   - i_gnt == 0: stay in IDLE.
//   - Multi-hot i_gnt: ignore it, set o_err_multi, stay in IDLE.
//  FSM XFER:
//   - i_gnt is ignored. The lock holds even if the arbiter changes the grant.
//   - o_ready[owner] = !o_valid | i_out_ready. All other o_ready bits are 0.
//   - Accept when i_valid[owner] & o_ready[owner]. The output register loads
//     data/last and o_valid = 1 on the next edge, so latency is 1 cycle.
//   - A downstream pop (o_valid & i_out_ready) with no accept in the same cycle
//     clears o_valid. Accept and pop in the same cycle sustain 1 flit/cycle.
//   - flit_cnt increments per accept.
//   - Accepted flit with i_last = 1: go to IDLE, pulse o_release.
//   - Watchdog: if flit_cnt == MAX_PKT_FLITS-1 at an accept without i_last, the
//     flit is loaded with o_last forced to 1, o_err_len is set, and the FSM goes
//     to IDLE with o_release.
//   - The FSM re-enters IDLE while the tail may still sit in the output register.
//     A new owner may be latched, but its first accept still obeys the
//     !o_valid | i_out_ready rule, so flits never overtake.
//  o_busy = (state == XFER). o_owner = owner in XFER, else 0.
//  o_pkt_cnt increments on o_valid & i_out_ready & o_last, and wraps 0xFFFF -> 0.
//  i_err_clr clears both sticky flags. If a clear and a new error occur in the
//   same cycle, the set wins.
// TESTING
//  1. i_gnt=4'b1000, input3 sends 3 flits (last on 3rd), i_out_ready=1 -> o_data
//     matches each flit 1 cycle later, o_release pulses once, o_pkt_cnt=1.
//  2. Mid-packet, i_gnt changes to 4'b0001 -> o_owner stays 4'b1000 and o_ready[0]=0
//     until input3's tail is accepted.
//  3. i_out_ready=0 for 5 cycles with o_valid=1 -> o_ready[owner]=0, o_data stable;
//     once released, throughput is 1 flit/cycle.
//  4. i_gnt=4'b0110 in IDLE -> no lock, o_err_multi=1; i_err_clr -> o_err_multi=0.
//  5. 20-flit packet with no last -> 16th flit leaves with o_last=1, o_err_len=1,
//     FSM returns to IDLE, and the 17th flit is not accepted.
//  6. reset_n low during XFER with o_valid=1 -> all outputs 0 immediately; after
//     reset release a fresh grant locks normally.

Source files
------------

// File: rtl/switch_output_port_if.sv
// Flit bus between the input side / arbiter and the output port stage.
//   i_gnt       one-hot grant from the arbiter (registered upstream)
//   i_valid     per-input flit valid
//   i_data      per-input flit data, input k at [k*DATA_W +: DATA_W]
//   i_last      per-input tail marker
//   o_ready     per-input accept (only the owner bit can be set)
//   o_valid     registered output flit valid
//   o_data      registered output flit data
//   o_last      registered output tail marker
//   i_out_ready downstream accept
// master: the side that drives flits and accepts output (testbench / fabric).
// slave:  the output port itself.
interface switch_output_port_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32
);
  logic [N_PORTS-1:0]        i_gnt;
  logic [N_PORTS-1:0]        i_valid;
  logic [N_PORTS*DATA_W-1:0] i_data;
  logic [N_PORTS-1:0]        i_last;
  logic [N_PORTS-1:0]        o_ready;
  logic                      o_valid;
  logic [DATA_W-1:0]         o_data;
  logic                      o_last;
  logic                      i_out_ready;

  modport master (
    output i_gnt, i_valid, i_data, i_last, i_out_ready,
    input  o_ready, o_valid, o_data, o_last
  );
  modport slave (
    input  i_gnt, i_valid, i_data, i_last, i_out_ready,
    output o_ready, o_valid, o_data, o_last
  );
endinterface

// File: rtl/switch_output_port.sv
// Output-port stage behind the fixed-priority arbiter. Locks to the granted
// input for a whole packet and forwards its flits through a one-entry
// registered output stage.
//   clk, reset_n   clock / async active-low reset
//   bus            flit bus (grant, per-input valid/data/last/ready, output stage)
//   i_err_clr      clears sticky error flags
//   o_busy         locked to an owner
//   o_owner        one-hot owner, 0 when idle
//   o_release      one-cycle pulse after the lock drops
//   o_pkt_cnt      packets delivered downstream (wraps)
//   o_err_multi    sticky: multi-hot grant seen while idle
//   o_err_len      sticky: packet truncated by the length watchdog
module switch_output_port #(
  parameter int N_PORTS       = 4,
  parameter int DATA_W        = 32,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  switch_output_port_if.slave  bus,
  input  logic                 i_err_clr,
  output logic                 o_busy,
  output logic [N_PORTS-1:0]   o_owner,
  output logic                 o_release,
  output logic [15:0]          o_pkt_cnt,
  output logic                 o_err_multi,
  output logic                 o_err_len
);
  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                           r_state, w_state_d;
  logic [N_PORTS-1:0]               r_owner;
  logic [CNT_W-1:0]                 r_cnt;
  logic                             r_valid, r_last, r_release, r_err_multi, r_err_len;
  logic [DATA_W-1:0]                r_data;
  logic [15:0]                      r_pkt_cnt;

  logic [N_PORTS-1:0][DATA_W-1:0]   w_in_data;
  logic [DATA_W-1:0]                w_own_data;
  logic                             w_own_valid, w_own_last, w_can_load, w_acc, w_wd, w_pop;
  logic                             w_gnt_1hot, w_multi, w_lock, w_done;

  assign w_in_data   = bus.i_data;
  assign w_own_valid = |(bus.i_valid & r_owner);
  assign w_own_last  = |(bus.i_last & r_owner);

  // Owner is one-hot, so an AND-OR mux is enough.
  always_comb begin
    w_own_data = '0;
    for (int k = 0; k < N_PORTS; k++)
      w_own_data = w_own_data | (w_in_data[k] & {DATA_W{r_owner[k]}});
  end

  // Output register can take a flit when empty or being drained this cycle;
  // this also keeps a new owner's first flit behind a previous tail.
  assign w_can_load = !r_valid || bus.i_out_ready;
  assign w_acc      = (r_state == XFER) && w_own_valid && w_can_load;
  assign w_wd       = w_acc && !w_own_last && (r_cnt == CNT_W'(MAX_PKT_FLITS - 1));
  assign w_pop      = r_valid && bus.i_out_ready;

  assign w_gnt_1hot = (bus.i_gnt != '0) && ((bus.i_gnt & (bus.i_gnt - 1'b1)) == '0);
  assign w_multi    = (r_state == IDLE) && (bus.i_gnt != '0) && !w_gnt_1hot;

  for (genvar k = 0; k < N_PORTS; k++) begin : g_rdy
    assign bus.o_ready[k] = (r_state == XFER) && r_owner[k] && w_can_load;
  end

  always_comb begin
    w_state_d = r_state;
    w_lock    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_1hot) begin
        w_state_d = XFER;
        w_lock    = 1'b1;
      end
      XFER: if (w_acc && (w_own_last || w_wd)) begin
        w_state_d = IDLE;
        w_done    = 1'b1;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_release   <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_multi <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_release <= w_done;
      if (w_lock) begin
        r_owner <= bus.i_gnt;
        r_cnt   <= '0;
      end else if (w_acc) begin
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_acc) begin
        r_valid <= 1'b1;
        r_data  <= w_own_data;
        r_last  <= w_own_last || w_wd;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (w_pop && r_last) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      // Set has priority over clear.
      if (w_multi)        r_err_multi <= 1'b1;
      else if (i_err_clr) r_err_multi <= 1'b0;
      if (w_wd)           r_err_len   <= 1'b1;
      else if (i_err_clr) r_err_len   <= 1'b0;
    end
  end

  assign bus.o_valid = r_valid;
  assign bus.o_data  = r_data;
  assign bus.o_last  = r_last;
  assign o_busy      = (r_state == XFER);
  assign o_owner     = (r_state == XFER) ? r_owner : '0;
  assign o_release   = r_release;
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_err_multi = r_err_multi;
  assign o_err_len   = r_err_len;
endmodule

// File: tb/tb_switch_output_port.sv
module tb_switch_output_port;
  localparam int NP = 4;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_err_clr;
  logic        o_busy, o_release, o_err_multi, o_err_len;
  logic [3:0]  o_owner;
  logic [15:0] o_pkt_cnt;

  switch_output_port_if #(.N_PORTS(NP), .DATA_W(DW)) bus();

  switch_output_port #(.N_PORTS(NP), .DATA_W(DW), .MAX_PKT_FLITS(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .i_err_clr(i_err_clr),
    .o_busy(o_busy), .o_owner(o_owner), .o_release(o_release),
    .o_pkt_cnt(o_pkt_cnt), .o_err_multi(o_err_multi), .o_err_len(o_err_len)
  );

  always #5 clk = ~clk;

  int          n_pass = 0, n_tot = 0;
  int          rel_cnt = 0;
  int          exp_pkts = 0;
  logic [32:0] sb[$];

  // Scoreboard: each downstream pop is checked against the oldest expected flit.
  always @(negedge clk) begin
    if (reset_n && bus.o_valid && bus.i_out_ready) begin
      logic [32:0] e;
      n_tot++;
      if (sb.size() == 0)
        $display("FAIL out_flit: got last=%b data=%h, expected nothing", bus.o_last, bus.o_data);
      else begin
        e = sb.pop_front();
        if ({bus.o_last, bus.o_data} !== e)
          $display("FAIL out_flit: got last=%b data=%h, expected last=%b data=%h",
                   bus.o_last, bus.o_data, e[32], e[31:0]);
        else n_pass++;
      end
    end
    if (reset_n && o_release) rel_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lock(input logic [3:0] g);
    bus.i_gnt = g;
    @(posedge clk); #1;
    bus.i_gnt = '0;
  endtask

  // Drives n flits on one input; returns how many were accepted before a
  // ready wait exceeded max_wait cycles. Flit 15 is expected with last forced.
  task automatic send_pkt(input int port, input int n, input logic [31:0] base,
                          input bit use_last, input int max_wait, output int acc);
    int w;
    logic l;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      l = use_last && (i == n - 1);
      bus.i_valid[port] = 1'b1;
      bus.i_data[port*DW +: DW] = base + i;
      bus.i_last[port] = l;
      w = 0;
      @(negedge clk);
      while (!bus.o_ready[port] && w < max_wait) begin
        @(negedge clk);
        w++;
      end
      if (!bus.o_ready[port]) break;
      sb.push_back({l || (i == 15), base + 32'(i)});
      acc++;
      @(posedge clk); #1;
    end
    bus.i_valid[port] = 1'b0;
    bus.i_last[port] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %h, expected %h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic test_reset;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_ready", 32'(bus.o_ready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_owner", 32'(o_owner), 0);
    chk("rst_release", 32'(o_release), 0);
    chk("rst_pkt_cnt", 32'(o_pkt_cnt), 0);
    chk("rst_errs", 32'({o_err_multi, o_err_len}), 0);
  endtask

  task automatic test_basic;
    int acc, r0;
    r0 = rel_cnt;
    lock(4'b1000);
    chk("basic_busy", 32'(o_busy), 1);
    chk("basic_owner", 32'(o_owner), 32'h8);
    fork
      send_pkt(3, 3, 32'hA000_0000, 1, 20, acc);
      begin
        int w = 0;
        @(negedge clk);
        while (!bus.o_ready[3] && w < 20) begin @(negedge clk); w++; end
        @(negedge clk);
        chk("basic_latency", {bus.o_valid, 31'(bus.o_data)}, {1'b1, 31'h2000_0000});
      end
    join
    chk("basic_acc", 32'(acc), 3);
    idle(3);
    exp_pkts++;
    chk("basic_release", 32'(rel_cnt - r0), 1);
    chk("basic_pkt_cnt", 32'(o_pkt_cnt), 32'(exp_pkts));
    chk("basic_idle", 32'(o_busy), 0);
  endtask

  task automatic test_lock_hold;
    int acc;
    lock(4'b1000);
    fork
      send_pkt(3, 8, 32'hB000_0000, 1, 20, acc);
      begin
        @(posedge clk); #1;
        bus.i_gnt = 4'b0001;
        bus.i_valid[0] = 1'b1;
        bus.i_data[0 +: DW] = 32'hDEAD_BEEF;
        repeat (4) begin
          @(negedge clk);
          chk("hold_owner", 32'(o_owner), 32'h8);
          chk("hold_ready0", 32'(bus.o_ready[0]), 0);
        end
        @(posedge clk); #1;
        bus.i_gnt = '0;
        bus.i_valid[0] = 1'b0;
      end
    join
    chk("hold_acc", 32'(acc), 8);
    idle(3);
    exp_pkts++;
    chk("hold_pkt_cnt", 32'(o_pkt_cnt), 32'(exp_pkts));
  endtask

  task automatic test_stall;
    int acc;
    lock(4'b0010);
    fork
      send_pkt(1, 8, 32'hC000_0000, 1, 30, acc);
      begin
        logic [31:0] held;
        int w = 0;
        bus.i_out_ready = 1'b0;
        @(negedge clk);
        while (!bus.o_valid && w < 20) begin @(negedge clk); w++; end
        held = bus.o_data;
        chk("stall_first", held, 32'hC000_0000);
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          chk("stall_ready", 32'(bus.o_ready[1]), 0);
          chk("stall_data", bus.o_data, held);
        end
        @(posedge clk); #1;
        bus.i_out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("stall_thru", 32'(bus.o_ready[1]), 1);
        end
      end
    join
    chk("stall_acc", 32'(acc), 8);
    idle(3);
    exp_pkts++;
    chk("stall_pkt_cnt", 32'(o_pkt_cnt), 32'(exp_pkts));
  endtask

  task automatic test_watchdog;
    int acc, r0;
    r0 = rel_cnt;
    lock(4'b0100);
    send_pkt(2, 20, 32'hD000_0000, 0, 8, acc);
    chk("wd_acc", 32'(acc), 16);
    chk("wd_busy", 32'(o_busy), 0);
    chk("wd_err_len", 32'(o_err_len), 1);
    chk("wd_release", 32'(rel_cnt - r0), 1);
    idle(2);
    exp_pkts++;
    chk("wd_pkt_cnt", 32'(o_pkt_cnt), 32'(exp_pkts));
  endtask

  task automatic test_err_multi;
    lock(4'b0110);
    chk("multi_busy", 32'(o_busy), 0);
    chk("multi_owner", 32'(o_owner), 0);
    chk("multi_err", 32'(o_err_multi), 1);
    // Clear coinciding with a new multi-hot grant: the set must win.
    bus.i_gnt = 4'b0101;
    i_err_clr = 1'b1;
    @(posedge clk); #1;
    bus.i_gnt = '0;
    i_err_clr = 1'b0;
    chk("multi_set_wins", 32'(o_err_multi), 1);
    chk("multi_clr_len", 32'(o_err_len), 0);
    i_err_clr = 1'b1;
    @(posedge clk); #1;
    i_err_clr = 1'b0;
    chk("multi_clr", 32'(o_err_multi), 0);
    chk("multi_still_idle", 32'(o_busy), 0);
  endtask

  task automatic test_reset_mid;
    int acc;
    bus.i_out_ready = 1'b0;
    lock(4'b0001);
    send_pkt(0, 1, 32'hE000_0000, 0, 5, acc);
    chk("rm_acc", 32'(acc), 1);
    chk("rm_pre_valid", 32'(bus.o_valid), 1);
    reset_n = 1'b0;
    #1;
    test_reset;
    sb.delete();
    exp_pkts = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.i_out_ready = 1'b1;
    lock(4'b0100);
    chk("rm_relock", 32'(o_owner), 32'h4);
    send_pkt(2, 2, 32'hF000_0000, 1, 20, acc);
    chk("rm_acc2", 32'(acc), 2);
    idle(3);
    exp_pkts++;
    chk("rm_pkt_cnt", 32'(o_pkt_cnt), 32'(exp_pkts));
  endtask

  initial begin
    reset_n = 1'b0;
    i_err_clr = 1'b0;
    bus.i_gnt = '0;
    bus.i_valid = '0;
    bus.i_data = '0;
    bus.i_last = '0;
    bus.i_out_ready = 1'b1;
    idle(2);
    test_reset;
    reset_n = 1'b1;
    idle(1);
    test_reset;
    test_basic;
    test_lock_hold;
    test_stall;
    test_watchdog;
    test_err_multi;
    test_reset_mid;
    idle(2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
